// File: rtl/tetris_pkg.sv
// Shared piece types and constants for the tetris block, plus the 7-bag validity check.
package tetris_pkg;

    typedef logic [2:0] piece_t;

    localparam int unsigned BAG_SIZE    = 7;
    localparam int unsigned PIECE_W     = 3;
    localparam int unsigned QUEUE_DEPTH = 2 * BAG_SIZE;
    localparam piece_t      PIECE_NONE  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DROP,
        ST_WAIT_DONE
    } disp_state_t;

    // Seven slots covering all seven codes 0..6 forces each to appear exactly once.
    function automatic logic is_valid_bag(input logic [BAG_SIZE*PIECE_W-1:0] bag);
        logic [7:0] seen;
        seen = '0;
        for (int unsigned i = 0; i < BAG_SIZE; i++) begin
            seen[bag[PIECE_W*i +: PIECE_W]] = 1'b1;
        end
        return seen == 8'h7f;
    endfunction

endpackage

// File: rtl/piece_queue.sv
// Circular piece buffer: 7-wide bag append, single head pop, registered head and preview taps.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int unsigned PREVIEW = 3,
    parameter int unsigned DEPTH   = QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [BAG_SIZE*PIECE_W-1:0]  bag,
    input  logic                         pop,
    output piece_t                       head,
    output logic                         head_valid,
    output logic [PIECE_W*PREVIEW-1:0]   preview,
    output logic [PREVIEW-1:0]           preview_valid,
    output logic [3:0]                   count
);

    piece_t                     mem_q [DEPTH];
    piece_t                     mem_d [DEPTH];
    logic [3:0]                 head_ptr_q, head_ptr_d;
    logic [3:0]                 wr_ptr_q, wr_ptr_d;
    logic [3:0]                 count_q, count_d;
    piece_t                     head_q, head_d;
    logic                       head_valid_q, head_valid_d;
    logic [PIECE_W*PREVIEW-1:0] preview_q, preview_d;
    logic [PREVIEW-1:0]         preview_valid_q, preview_valid_d;
    logic                       pop_ok;

    function automatic logic [3:0] wrap(input logic [4:0] s);
        logic [4:0] r;
        r = (s >= 5'(DEPTH)) ? s - 5'(DEPTH) : s;
        return r[3:0];
    endfunction

    always_comb begin
        mem_d      = mem_q;
        head_ptr_d = head_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pop_ok     = pop && (count_q != '0);

        if (load) begin
            for (int unsigned i = 0; i < BAG_SIZE; i++) begin
                mem_d[wrap({1'b0, wr_ptr_q} + 5'(i))] = bag[PIECE_W*i +: PIECE_W];
            end
            wr_ptr_d = wrap({1'b0, wr_ptr_q} + 5'(BAG_SIZE));
        end
        if (pop_ok) begin
            head_ptr_d = wrap({1'b0, head_ptr_q} + 5'd1);
        end
        count_d = count_q + (load ? 4'(BAG_SIZE) : 4'd0) - (pop_ok ? 4'd1 : 4'd0);

        // Taps read the post-update contents so outputs can be registered without extra latency.
        head_valid_d = (count_d != '0);
        head_d       = head_valid_d ? mem_d[head_ptr_d] : PIECE_NONE;
        for (int unsigned k = 0; k < PREVIEW; k++) begin
            preview_valid_d[k] = (32'(count_d) > k + 1);
            preview_d[PIECE_W*k +: PIECE_W] = preview_valid_d[k]
                ? mem_d[wrap({1'b0, head_ptr_d} + 5'(k + 1))] : PIECE_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q           <= '{default: PIECE_NONE};
            head_ptr_q      <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            head_q          <= PIECE_NONE;
            head_valid_q    <= 1'b0;
            preview_q       <= {PREVIEW{PIECE_NONE}};
            preview_valid_q <= '0;
        end else begin
            mem_q           <= mem_d;
            head_ptr_q      <= head_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            head_q          <= head_d;
            head_valid_q    <= head_valid_d;
            preview_q       <= preview_d;
            preview_valid_q <= preview_valid_d;
        end
    end

    assign head          = head_q;
    assign head_valid    = head_valid_q;
    assign preview       = preview_q;
    assign preview_valid = preview_valid_q;
    assign count         = count_q;

endmodule

// File: rtl/piece_dispenser.sv
// Requests 7-bags from the generator, validates them and feeds pieces to the game controller.
module piece_dispenser
    import tetris_pkg::*;
#(
    parameter int unsigned PREVIEW = 3,
    parameter int unsigned DEPTH   = QUEUE_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        newbag,
    input  logic                        ready,
    input  logic [BAG_SIZE*PIECE_W-1:0] pieces,
    input  logic                        next_req,
    output logic                        piece_valid,
    output logic [PIECE_W-1:0]          current_piece,
    output logic [PIECE_W*PREVIEW-1:0]  preview,
    output logic [PREVIEW-1:0]          preview_valid,
    output logic                        bag_error,
    output logic [3:0]                  count
);

    disp_state_t state_q, state_d;
    logic        newbag_q, newbag_d;
    logic        bag_error_q, bag_error_d;
    logic        load;
    logic [3:0]  count_w;

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        bag_error_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_w <= 4'(BAG_SIZE)) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT_DROP;
            end
            // A ready still high from the previous bag must fall before we trust it again.
            ST_WAIT_DROP: begin
                if (!ready) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (ready) begin
                    if (is_valid_bag(pieces)) begin
                        load    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        bag_error_d = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        newbag_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            newbag_q    <= 1'b0;
            bag_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            newbag_q    <= newbag_d;
            bag_error_q <= bag_error_d;
        end
    end

    piece_queue #(
        .PREVIEW (PREVIEW),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .bag           (pieces),
        .pop           (next_req),
        .head          (current_piece),
        .head_valid    (piece_valid),
        .preview       (preview),
        .preview_valid (preview_valid),
        .count         (count_w)
    );

    assign newbag    = newbag_q;
    assign bag_error = bag_error_q;
    assign count     = count_w;

endmodule

// File: tb/tb_piece_dispenser.sv
// Bench for piece_dispenser: queue-based reference model checked every cycle, directed and random stimulus.
module tb_piece_dispenser;

    localparam int P = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          newbag;
    logic          ready = 1'b0;
    logic [20:0]   pieces = '0;
    logic          next_req = 1'b0;
    logic          piece_valid;
    logic [2:0]    current_piece;
    logic [3*P-1:0] preview;
    logic [P-1:0]  preview_valid;
    logic          bag_error;
    logic [3:0]    count;

    int n_chk  = 0;
    int n_fail = 0;

    piece_dispenser #(.PREVIEW(P)) dut (
        .clk           (clk),
        .reset         (reset),
        .newbag        (newbag),
        .ready         (ready),
        .pieces        (pieces),
        .next_req      (next_req),
        .piece_valid   (piece_valid),
        .current_piece (current_piece),
        .preview       (preview),
        .preview_valid (preview_valid),
        .bag_error     (bag_error),
        .count         (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   mq[$];
    int   phase;          // 0 idle, 1 request, 2 wait for ready low, 3 wait for ready high
    bit   live = 0;
    logic e_newbag, e_err;

    function automatic bit bag_ok(input logic [20:0] b);
        int hits [8];
        logic [20:0] t;
        t = b;
        for (int i = 0; i < 8; i++) hits[i] = 0;
        for (int i = 0; i < 7; i++) hits[t[3*i +: 3]]++;
        for (int i = 0; i < 7; i++) if (hits[i] != 1) return 0;
        return 1;
    endfunction

    task automatic model_step();
        bit popped, loaded, rejected;
        logic [20:0] b;
        if (reset) begin
            mq.delete();
            phase    = 0;
            e_newbag = 0;
            e_err    = 0;
            live     = 1;
        end else if (live) begin
            b        = pieces;
            popped   = next_req && (mq.size() > 0);
            loaded   = (phase == 3) && ready && bag_ok(b);
            rejected = (phase == 3) && ready && !bag_ok(b);
            case (phase)
                0: if (mq.size() <= 7) phase = 1;
                1: phase = 2;
                2: if (!ready) phase = 3;
                default: if (ready) phase = loaded ? 0 : 1;
            endcase
            if (popped) void'(mq.pop_front());
            if (loaded) for (int i = 0; i < 7; i++) mq.push_back(int'(b[3*i +: 3]));
            e_newbag = (phase == 1);
            e_err    = rejected;
        end
    endtask

    task automatic model_compare();
        logic [3*P-1:0] ep;
        logic [P-1:0]   ev;
        for (int k = 0; k < P; k++) begin
            ev[k] = (mq.size() > k + 1);
            ep[3*k +: 3] = ev[k] ? 3'(mq[k + 1]) : 3'd7;
        end
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_piece_valid", 32'(piece_valid), 32'(mq.size() > 0));
        chk("m_current", 32'(current_piece), (mq.size() > 0) ? 32'(mq[0]) : 32'd7);
        chk("m_preview", 32'(preview), 32'(ep));
        chk("m_preview_valid", 32'(preview_valid), 32'(ev));
        chk("m_newbag", 32'(newbag), 32'(e_newbag));
        chk("m_bag_error", 32'(bag_error), 32'(e_err));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (live) model_compare();
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // Three cycles with ready low reach the sampling state from idle, request or either wait state.
    task automatic load_bag(input logic [20:0] b, input logic pop_too);
        ready = 1'b0;
        repeat (3) tick();
        pieces   = b;
        ready    = 1'b1;
        next_req = pop_too;
        tick();
        next_req = 1'b0;
    endtask

    task automatic pop_n(input int n);
        next_req = 1'b1;
        repeat (n) tick();
        next_req = 1'b0;
    endtask

    function automatic logic [20:0] shuffled_bag();
        int a [7];
        int j, t;
        logic [20:0] r;
        for (int i = 0; i < 7; i++) a[i] = i;
        for (int i = 6; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = a[i]; a[i] = a[j]; a[j] = t;
        end
        for (int i = 0; i < 7; i++) r[3*i +: 3] = 3'(a[i]);
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_current", 32'(current_piece), 32'd7);
        reset = 1'b0;

        // First request: idle cycle, then the request cycle.
        chk("nb_cycle1", 32'(newbag), 32'd0);
        tick();
        chk("nb_cycle2", 32'(newbag), 32'd1);
        tick();
        chk("nb_cycle3", 32'(newbag), 32'd0);

        load_bag(21'o6543210, 1'b0);
        chk("bag1_count", 32'(count), 32'd7);
        load_bag(21'o6543210, 1'b0);
        chk("bag2_count", 32'(count), 32'd14);
        chk("bag2_current", 32'(current_piece), 32'd0);
        chk("bag2_preview", 32'(preview), 32'(9'o321));
        chk("bag2_pvalid", 32'(preview_valid), 32'b111);
        ready = 1'b0;

        // Drain all fourteen pieces, then a request against an empty queue.
        for (int i = 0; i < 14; i++) begin
            chk("drain_head", 32'(current_piece), 32'(i % 7));
            next_req = 1'b1;
            tick();
        end
        chk("drain_valid", 32'(piece_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        tick();
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_current", 32'(current_piece), 32'd7);
        next_req = 1'b0;

        // Rejected bag then a good one.
        pieces = 21'o6543211;
        ready  = 1'b1;
        tick();
        chk("bad_error", 32'(bag_error), 32'd1);
        chk("bad_newbag", 32'(newbag), 32'd1);
        chk("bad_count", 32'(count), 32'd0);
        tick();
        chk("bad_error_once", 32'(bag_error), 32'd0);
        load_bag(21'o0123456, 1'b0);
        chk("rev_count", 32'(count), 32'd7);
        chk("rev_current", 32'(current_piece), 32'd6);
        chk("rev_preview", 32'(preview), 32'(9'o345));

        // Pop on the same edge the bag is sampled.
        load_bag(21'o6543210, 1'b1);
        chk("coinc_count", 32'(count), 32'd13);
        chk("coinc_current", 32'(current_piece), 32'd5);
        chk("coinc_preview", 32'(preview), 32'(9'o234));
        pop_n(6);
        chk("coinc_slot0_pos6", 32'(current_piece), 32'd0);
        chk("coinc_after_preview", 32'(preview), 32'(9'o321));

        // Short queue: partially valid preview, then a load fills it across the bag boundary.
        pop_n(5);
        chk("short_count", 32'(count), 32'd2);
        chk("short_pvalid", 32'(preview_valid), 32'b001);
        chk("short_preview", 32'(preview), 32'(9'o776));
        load_bag(21'o2104635, 1'b0);
        chk("fill_count", 32'(count), 32'd9);
        chk("fill_preview", 32'(preview), 32'(9'o356));
        chk("fill_pvalid", 32'(preview_valid), 32'b111);

        // Reset while the FSM is sampling a valid bag.
        pop_n(2);
        ready = 1'b0;
        repeat (4) tick();
        pieces = 21'o6543210;
        ready  = 1'b1;
        reset  = 1'b1;
        tick();
        chk("mid_rst_newbag", 32'(newbag), 32'd0);
        chk("mid_rst_valid", 32'(piece_valid), 32'd0);
        chk("mid_rst_current", 32'(current_piece), 32'd7);
        chk("mid_rst_preview", 32'(preview), 32'(9'o777));
        chk("mid_rst_pvalid", 32'(preview_valid), 32'd0);
        chk("mid_rst_error", 32'(bag_error), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        chk("mid_nb_cycle1", 32'(newbag), 32'd0);
        tick();
        chk("mid_nb_cycle2", 32'(newbag), 32'd1);
        tick();
        chk("mid_nb_cycle3", 32'(newbag), 32'd0);
        chk("mid_no_load", 32'(count), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            next_req = ($urandom_range(0, 99) < 45);
            reset    = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 5) == 0) begin
                if (ready) begin
                    ready = 1'b0;
                end else begin
                    pieces = ($urandom_range(0, 4) == 0) ? 21'($urandom()) : shuffled_bag();
                    ready  = 1'b1;
                end
            end
            tick();
        end
        reset    = 1'b0;
        next_req = 1'b0;
        ready    = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
